// File: rtl/memory_stage.sv
// MEM pipeline stage: data-memory access over req/ack, branch resolve,
// and the MEM/WB register feeding write-back.
module memory_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        branch_in,
   input  logic        jump_in,
   input  logic        memread_in,
   input  logic        memwrite_in,
   input  logic        regwrite_in,
   input  logic        memtoreg_in,
   input  logic [31:0] adder_in,
   input  logic        aluzero_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] readdata2_in,
   input  logic [4:0]  writereg_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_out,
   output logic        pcsrc_out,
   output logic [31:0] branch_target,
   output logic        jump_out,
   output logic        wb_valid,
   output logic        regwrite_out,
   output logic        memtoreg_out,
   output logic [31:0] memdata_out,
   output logic [31:0] alu_out,
   output logic [4:0]  writereg_out,
   output logic        err_out
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          memop;
   logic          misaligned;
   logic          timeout_hit;

   // A branch never starts a memory access.
   assign memop       = (memread_in | memwrite_in) & ~branch_in;
   assign misaligned  = alu_in[1:0] != 2'b00;
   assign timeout_hit = (state == ACCESS) & ~dmem_ack & (cnt == CNT_LAST);

   // Stall is also released in the abort cycle so the held load
   // retires instead of being re-issued.
   always_comb begin
      stall_out = 1'b0;
      unique case (state)
         IDLE:    stall_out = ex_valid & memop & ~misaligned;
         ACCESS:  stall_out = ~dmem_ack & ~timeout_hit;
         default: stall_out = 1'b0;
      endcase
   end

   assign pcsrc_out     = ex_valid & branch_in & aluzero_in & ~stall_out;
   assign branch_target = adder_in;
   assign jump_out      = ex_valid & jump_in;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         wb_valid     <= 1'b0;
         regwrite_out <= 1'b0;
         memtoreg_out <= 1'b0;
         memdata_out  <= '0;
         alu_out      <= '0;
         writereg_out <= '0;
         err_out      <= 1'b0;
      end else begin
         err_out <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!ex_valid) begin
                  wb_valid <= 1'b0;
               end else if (!memop) begin
                  wb_valid     <= 1'b1;
                  regwrite_out <= regwrite_in;
                  memtoreg_out <= memtoreg_in;
                  memdata_out  <= '0;
                  alu_out      <= alu_in;
                  writereg_out <= writereg_in;
               end else if (misaligned) begin
                  wb_valid     <= 1'b1;
                  regwrite_out <= 1'b0;
                  memtoreg_out <= memtoreg_in;
                  memdata_out  <= '0;
                  alu_out      <= alu_in;
                  writereg_out <= writereg_in;
                  err_out      <= 1'b1;
               end else begin
                  wb_valid   <= 1'b0;
                  state      <= ACCESS;
                  cnt        <= '0;
                  dmem_req   <= 1'b1;
                  dmem_we    <= memwrite_in;
                  dmem_addr  <= {alu_in[31:2], 2'b00};
                  dmem_wdata <= readdata2_in;
               end
            end
            ACCESS: begin
               if (dmem_ack || timeout_hit) begin
                  state        <= IDLE;
                  dmem_req     <= 1'b0;
                  wb_valid     <= 1'b1;
                  regwrite_out <= dmem_ack ? regwrite_in : 1'b0;
                  memtoreg_out <= memtoreg_in;
                  memdata_out  <= (dmem_ack && !dmem_we) ? dmem_rdata : '0;
                  alu_out      <= alu_in;
                  writereg_out <= writereg_in;
                  err_out      <= ~dmem_ack;
               end else begin
                  wb_valid <= 1'b0;
                  cnt      <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after.
module tb_memory_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic        branch_in;
   logic        jump_in;
   logic        memread_in;
   logic        memwrite_in;
   logic        regwrite_in;
   logic        memtoreg_in;
   logic [31:0] adder_in;
   logic        aluzero_in;
   logic [31:0] alu_in;
   logic [31:0] readdata2_in;
   logic [4:0]  writereg_in;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall_out;
   logic        pcsrc_out;
   logic [31:0] branch_target;
   logic        jump_out;
   logic        wb_valid;
   logic        regwrite_out;
   logic        memtoreg_out;
   logic [31:0] memdata_out;
   logic [31:0] alu_out;
   logic [4:0]  writereg_out;
   logic        err_out;

   int vectors = 0;
   int miscompares = 0;
   int stall_cnt;

   always #5 clock = ~clock;

   memory_stage #(.TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .ex_valid(ex_valid),
      .branch_in(branch_in), .jump_in(jump_in),
      .memread_in(memread_in), .memwrite_in(memwrite_in),
      .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
      .adder_in(adder_in), .aluzero_in(aluzero_in), .alu_in(alu_in),
      .readdata2_in(readdata2_in), .writereg_in(writereg_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .stall_out(stall_out),
      .pcsrc_out(pcsrc_out), .branch_target(branch_target),
      .jump_out(jump_out), .wb_valid(wb_valid),
      .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
      .memdata_out(memdata_out), .alu_out(alu_out),
      .writereg_out(writereg_out), .err_out(err_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 0; branch_in = 0; jump_in = 0;
      memread_in = 0; memwrite_in = 0; regwrite_in = 0;
      memtoreg_in = 0; adder_in = 0; aluzero_in = 0;
      alu_in = 0; readdata2_in = 0; writereg_in = 0;
      dmem_rdata = 0; dmem_ack = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      step(); step();
      reset = 0;
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_wbv", 32'(wb_valid), 32'd0);
      chk("rst_err", 32'(err_out), 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_alu", alu_out, 32'd0);

      // ALU op
      step();
      ex_valid = 1; alu_in = 32'h42; writereg_in = 5; regwrite_in = 1;
      #1;
      chk("alu_stall", 32'(stall_out), 32'd0);
      step();
      idle_inputs();
      #1;
      chk("alu_wbv", 32'(wb_valid), 32'd1);
      chk("alu_out", alu_out, 32'h42);
      chk("alu_wreg", 32'(writereg_out), 32'd5);
      chk("alu_rw", 32'(regwrite_out), 32'd1);
      chk("alu_mdata", memdata_out, 32'd0);
      step();
      #1;
      chk("alu_bubble", 32'(wb_valid), 32'd0);

      // Load, ack after 3 wait cycles
      ex_valid = 1; memread_in = 1; memtoreg_in = 1; regwrite_in = 1;
      alu_in = 32'h100; writereg_in = 7;
      #1;
      stall_cnt = 0;
      if (stall_out) stall_cnt++;
      step();
      chk("ld_req", 32'(dmem_req), 32'd1);
      chk("ld_we", 32'(dmem_we), 32'd0);
      chk("ld_addr", dmem_addr, 32'h100);
      for (int i = 0; i < 3; i++) begin
         if (stall_out) stall_cnt++;
         step();
      end
      dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
      #1;
      if (stall_out) stall_cnt++;
      chk("ld_stall_n", 32'(stall_cnt), 32'd4);
      chk("ld_ack_stall", 32'(stall_out), 32'd0);
      step();
      idle_inputs();
      #1;
      chk("ld_wbv", 32'(wb_valid), 32'd1);
      chk("ld_data", memdata_out, 32'hDEAD_BEEF);
      chk("ld_m2r", 32'(memtoreg_out), 32'd1);
      chk("ld_wreg", 32'(writereg_out), 32'd7);
      chk("ld_req_drop", 32'(dmem_req), 32'd0);

      // Store
      step();
      ex_valid = 1; memwrite_in = 1; alu_in = 32'h204;
      readdata2_in = 32'h1234;
      #1;
      chk("st_stall", 32'(stall_out), 32'd1);
      step();
      for (int i = 0; i < 2; i++) begin
         chk("st_we", 32'(dmem_we), 32'd1);
         chk("st_addr", dmem_addr, 32'h204);
         chk("st_wdata", dmem_wdata, 32'h1234);
         step();
      end
      dmem_ack = 1; dmem_rdata = 32'h5555_5555;
      step();
      idle_inputs();
      #1;
      chk("st_wbv", 32'(wb_valid), 32'd1);
      chk("st_mdata", memdata_out, 32'd0);
      chk("st_req_drop", 32'(dmem_req), 32'd0);

      // Branch and jump
      step();
      ex_valid = 1; branch_in = 1; aluzero_in = 1; adder_in = 32'h40;
      #1;
      chk("br_taken", 32'(pcsrc_out), 32'd1);
      chk("br_target", branch_target, 32'h40);
      aluzero_in = 0;
      #1;
      chk("br_not", 32'(pcsrc_out), 32'd0);
      branch_in = 0; jump_in = 1;
      #1;
      chk("jump", 32'(jump_out), 32'd1);
      step();
      idle_inputs();

      // Misaligned load
      step();
      ex_valid = 1; memread_in = 1; regwrite_in = 1; alu_in = 32'h102;
      #1;
      chk("mis_stall", 32'(stall_out), 32'd0);
      step();
      idle_inputs();
      #1;
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_err", 32'(err_out), 32'd1);
      chk("mis_rw", 32'(regwrite_out), 32'd0);
      chk("mis_wbv", 32'(wb_valid), 32'd1);
      step();
      chk("mis_err_pulse", 32'(err_out), 32'd0);

      // Load that never gets an ack
      ex_valid = 1; memread_in = 1; regwrite_in = 1; alu_in = 32'h300;
      step();
      for (int i = 0; i < 16; i++) begin
         chk("to_req_held", 32'(dmem_req), 32'd1);
         step();
      end
      idle_inputs();
      #1;
      chk("to_req_drop", 32'(dmem_req), 32'd0);
      chk("to_err", 32'(err_out), 32'd1);
      chk("to_rw", 32'(regwrite_out), 32'd0);
      chk("to_wbv", 32'(wb_valid), 32'd1);
      step();

      // Reset mid-access, late ack ignored
      ex_valid = 1; memread_in = 1; regwrite_in = 1; alu_in = 32'h400;
      step();
      chk("ra_req", 32'(dmem_req), 32'd1);
      idle_inputs();
      reset = 1;
      step(); step();
      reset = 0;
      chk("ra_req_drop", 32'(dmem_req), 32'd0);
      chk("ra_wbv", 32'(wb_valid), 32'd0);
      chk("ra_err", 32'(err_out), 32'd0);
      dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
      step();
      dmem_ack = 0;
      #1;
      chk("ra_late_wbv", 32'(wb_valid), 32'd0);
      chk("ra_late_req", 32'(dmem_req), 32'd0);
      chk("ra_late_data", memdata_out, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
